shift_reg_universal: RTL and testbench

- Parametrised universal shift register: the next-generation successor of the single-bit posedge D flip-flop.
- Holds a WIDTH-bit word updated on posedge clk, with synchronous reset.
- Supports four modes: hold, shift right, shift left and parallel load.
- Tracks shifts since the last load with a saturating counter and flags a completed serial frame.
- Used as the SIPO/PISO building block for serial links in the design.

---
 rtl/shift_reg_universal.sv | 91 +++++++++
 tb/tb_shift_reg_universal.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_universal.sv
// Universal WIDTH-bit shift register: hold, shift right, shift left, parallel load,
// with a saturating shifts-since-load counter. Optional rotate: define SHIFT_REG_ROTATE_EN.
module shift_reg_universal #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  localparam int              CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             si_r,
  input  logic             si_l,
  input  logic             rot,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHR   = 2'b01,
    MODE_SHL   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             feed_r, feed_l;

`ifdef SHIFT_REG_ROTATE_EN
  assign feed_r = rot ? q_q[0]       : si_r;
  assign feed_l = rot ? q_q[WIDTH-1] : si_l;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign feed_r     = si_r;
  assign feed_l     = si_l;
`endif

  // Both directions share one counter; it sticks at WIDTH until a load or reset.
  assign cnt_inc = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    q_d   = q_q;
    cnt_d = cnt_q;
    if (en) begin
      unique case (mode_e'(mode))
        MODE_HOLD: ;
        MODE_SHR: begin
          q_d   = {feed_r, q_q[WIDTH-1:1]};
          cnt_d = cnt_inc;
        end
        MODE_SHL: begin
          q_d   = {q_q[WIDTH-2:0], feed_l};
          cnt_d = cnt_inc;
        end
        MODE_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= RESET_VALUE;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q          = q_q;
  assign shift_cnt  = cnt_q;
  assign so_r       = q_q[0];
  assign so_l       = q_q[WIDTH-1];
  assign frame_done = (cnt_q == CNT_FULL);

endmodule

// File: tb/tb_shift_reg_universal.sv
// Self-checking bench for shift_reg_universal: directed vector table plus randomized
// run against an arithmetic reference model. Honours SHIFT_REG_ROTATE_EN if defined.
module tb_shift_reg_universal;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst, en, si_r, si_l, rot;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             so_r, so_l, frame_done;
  logic [CNT_W-1:0] shift_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  shift_reg_universal #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .si_r       (si_r),
    .si_l       (si_l),
    .rot        (rot),
    .d          (d),
    .q          (q),
    .so_r       (so_r),
    .so_l       (so_l),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en;
    logic [1:0] mode;
    logic       si_r, si_l, rot;
    logic [7:0] d;
    logic [7:0] exp_q;
    int         exp_cnt;
    logic       exp_fd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [1:0] m, input logic sr,
                     input logic sl, input logic rt, input logic [7:0] dd,
                     input logic [7:0] eq, input int ec, input logic ef);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.si_r = sr; v.si_l = sl; v.rot = rt; v.d = dd;
    v.exp_q = eq; v.exp_cnt = ec; v.exp_fd = ef;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic sr,
                       input logic sl, input logic rt, input logic [7:0] dd);
    rst = r; en = e; mode = m; si_r = sr; si_l = sl; rot = rt; d = dd;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] eq, input int ec, input logic ef);
    check({tag, ".q"},          32'(q),          32'(eq));
    check({tag, ".shift_cnt"},  32'(shift_cnt),  32'(ec));
    check({tag, ".frame_done"}, 32'(frame_done), 32'(ef));
    check({tag, ".so_r"},       32'(so_r),       32'(eq & 8'h01));
    check({tag, ".so_l"},       32'(so_l),       32'(eq >> 7));
  endtask

  // Reference model: plain integer arithmetic over the mode rules.
  int m_q, m_cnt;

  task automatic model_step(input logic r, input logic e, input logic [1:0] m, input logic sr,
                            input logic sl, input logic rt, input logic [7:0] dd);
    int fin;
    if (r) begin
      m_q = 0; m_cnt = 0;
    end else if (e) begin
      if (m == 2'd1 || m == 2'd2) begin
        if (m == 2'd1) begin
          fin = int'(sr);
`ifdef SHIFT_REG_ROTATE_EN
          if (rt) fin = m_q % 2;
`endif
          m_q = (m_q / 2) + fin * 128;
        end else begin
          fin = int'(sl);
`ifdef SHIFT_REG_ROTATE_EN
          if (rt) fin = m_q / 128;
`endif
          m_q = ((m_q * 2) % 256) + fin;
        end
        if (m_cnt < WIDTH) m_cnt++;
      end else if (m == 2'd3) begin
        m_q = int'(dd); m_cnt = 0;
      end
    end
  endtask

  logic [7:0] sipo_bits [8] = '{1, 1, 0, 0, 1, 0, 1, 0};
  logic [7:0] rot_exp [3];

  initial begin
    int acc;
    drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'hFF);

    // Reset wins over load
    add(1, 1, 2'b11, 0, 0, 0, 8'hFF, 8'h00, 0, 0);
    add(1, 1, 2'b11, 0, 0, 0, 8'hFF, 8'h00, 0, 0);
    // Load then hold, then disabled shift
    add(0, 1, 2'b11, 0, 0, 0, 8'hA5, 8'hA5, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 2'b00, 1, 1, 0, 8'h00, 8'hA5, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 2'b01, 1, 1, 0, 8'h00, 8'hA5, 0, 0);
    // PISO right shift of A5, plus a 9th saturated shift
    add(0, 1, 2'b11, 0, 0, 0, 8'hA5, 8'hA5, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 1, 2'b01, 0, 0, 0, 8'h00, 8'(8'hA5 >> k), k, k == 8);
    add(0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h00, 8, 1);
    // SIPO left shift building CA, then load clears counter
    add(1, 0, 2'b00, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      acc = (acc * 2 + int'(sipo_bits[k])) % 256;
      add(0, 1, 2'b10, 0, sipo_bits[k][0], 0, 8'h00, 8'(acc), k + 1, k == 7);
    end
    add(0, 1, 2'b11, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    // Mid-frame reset
    add(0, 1, 2'b11, 0, 0, 0, 8'h3C, 8'h3C, 0, 0);
    add(0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h1E, 1, 0);
    add(0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h0F, 2, 0);
    add(0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h07, 3, 0);
    add(1, 1, 2'b01, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    add(0, 1, 2'b01, 0, 0, 0, 8'h00, 8'h00, 1, 0);
    // Rotate (or plain zero-fill shift when rotate is not built in)
`ifdef SHIFT_REG_ROTATE_EN
    rot_exp = '{8'hC0, 8'h81, 8'h03};
`else
    rot_exp = '{8'h40, 8'h80, 8'h00};
`endif
    add(0, 1, 2'b11, 0, 0, 0, 8'h81, 8'h81, 0, 0);
    add(0, 1, 2'b01, 0, 0, 1, 8'h00, rot_exp[0], 1, 0);
    add(0, 1, 2'b10, 0, 0, 1, 8'h00, rot_exp[1], 2, 0);
    add(0, 1, 2'b10, 0, 0, 1, 8'h00, rot_exp[2], 3, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].si_r, vecs[i].si_l, vecs[i].rot,
            vecs[i].d);
      tick();
      check_state($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_fd);
    end

    // Hand-written: frame_done must be low on the 7th shift and rise on the 8th.
    drive(0, 1, 2'b11, 0, 0, 0, 8'hFF);
    tick();
    drive(0, 1, 2'b10, 0, 1, 0, 8'h00);
    for (int k = 1; k <= 7; k++) tick();
    check("seq.fd_before_8th", 32'(frame_done), 32'd0);
    tick();
    check("seq.fd_on_8th", 32'(frame_done), 32'd1);
    check("seq.cnt_on_8th", 32'(shift_cnt), 32'd8);

    // Randomized run against the reference model
    drive(1, 0, 2'b00, 0, 0, 0, 8'h00);
    tick();
    m_q = 0; m_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      logic       r_r, r_e, r_sr, r_sl, r_rt;
      logic [1:0] r_m;
      logic [7:0] r_d;
      r_r  = ($urandom_range(0, 39) == 0);
      r_e  = ($urandom_range(0, 3) != 0);
      // Bias towards shifts so frames complete and saturate
      r_m  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_sr = 1'($urandom);
      r_sl = 1'($urandom);
      r_rt = 1'($urandom);
      r_d  = 8'($urandom);
      drive(r_r, r_e, r_m, r_sr, r_sl, r_rt, r_d);
      model_step(r_r, r_e, r_m, r_sr, r_sl, r_rt, r_d);
      tick();
      check_state($sformatf("rnd%0d", i), 8'(m_q), m_cnt, m_cnt == WIDTH);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
